fft_frame_streamer: RTL and testbench
=====================================

Name: fft_frame_streamer

Overview:
- Parametrised framing front-end for the FFT core, placed between the audio sample stream and the FFT slave data port.
- Buffers incoming real samples in a circular store and emits FRAME_LEN-sample frames, oldest sample first, with configurable overlap (HOP).
- Packs each sample as {imag=0, real=sample}, generates m_tlast, and zero-pads the final partial frame of an utterance on s_last.
- Counts emitted frames.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- FRAME_LEN, 256: samples per frame; power of 2, range 4..4096.
- HOP, 128: new samples per frame after the first; 1 <= HOP <= FRAME_LEN. HOP=FRAME_LEN means no overlap.
- CNT_W, 16: width of frame_count.

Ports:
- sclk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- s_data, in, DATA_W: input sample.
- s_valid, in, 1: input sample valid.
- s_last, in, 1: last sample of the utterance; qualified by s_valid && s_ready.
- s_ready, out, 1: block accepts a sample.
- m_data, out, 2*DATA_W: {DATA_W'b0 imag, sample real} to the FFT slave.
- m_valid, out, 1: output valid.
- m_ready, in, 1: FFT slave ready.
- m_last, out, 1: high on the last sample of each frame.
- frame_count, out, CNT_W: frames fully emitted; wraps modulo 2^CNT_W.
- busy, out, 1: high in every state except FILL with fill count 0.

Behaviour:
- Reset (async assert, sync release): s_ready=0, m_valid=0, m_last=0, m_data=0, frame_count=0, busy=0; state=FILL; fill count=0; write pointer=0. s_ready rises on the first edge after release.
- Handshakes follow AXI-stream rules:
  - A transfer occurs on a clock edge where valid && ready.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable.
  - m_valid never drops without a transfer.
- State FILL (initial frame):
  - s_ready=1; each transfer writes the store at wptr, increments wptr modulo FRAME_LEN, and increments the fill count.
  - When the FRAME_LEN-th sample transfers: go to EMIT, with read start = wptr after the write.
- State EMIT:
  - s_ready=0. Stream FRAME_LEN samples from read start, oldest first.
  - m_valid rises exactly 2 edges after the frame-completing input transfer.
  - No bubbles inside a frame while m_ready=1.
  - m_last=1 only on the FRAME_LEN-th output.
  - On the m_last transfer: frame_count increments.
    - If a flush is pending: clear it, fill count=0, wptr=0, go to FILL.
    - Otherwise go to REFILL.
- State REFILL:
  - s_ready=1. Accept HOP samples into the oldest slots.
  - After the HOP-th transfer go to EMIT, with read start = new wptr.
  - The frame then holds the newest FRAME_LEN samples.
- State PAD:
  - Entered when s_last transfers in FILL or REFILL and that transfer does not complete the frame.
  - s_ready=0. Write zeros, one per cycle, until the frame is complete, then go to EMIT with flush pending.
  - If the s_last transfer itself completes the frame, go straight to EMIT with flush pending.
  - After a flush, the next utterance starts from an empty store; no samples carry over.
- s_last in FILL with fill count 0 cannot occur once any sample has been accepted. If s_last arrives on the very first sample, the frame is that sample plus FRAME_LEN-1 zeros.
- Store reads use a registered synchronous-read RAM (1-cycle latency). An output skid/prefetch register holds the next word so that m_ready toggling causes no loss or duplication.
- frame_count wrap: 2^CNT_W-1 -> 0 with no flag.
- Reset asserted mid-frame: outputs return to reset values immediately. Partial frames are discarded and never resumed.

Decomposition:
- Shared package fft_pkg holds:
  - the state encoding (FILL, EMIT, REFILL, PAD);
  - the address width function clog2(FRAME_LEN);
  - the complex-pack helper {imag, real}.
- One natural sub-module: frame_sample_ram, a simple dual-port RAM of FRAME_LEN x DATA_W with one write port, one registered read port and no reset on contents.

Test Plan:
- FRAME_LEN=8, HOP=8, input samples 1..16 at full rate, m_ready=1 -> two frames 1..8 and 9..16. m_last on 8 and 16. frame_count=2. m_data imag half=0 throughout.
- FRAME_LEN=8, HOP=4, input 1..16 -> frames [1..8], [5..12], [9..16]. frame_count=3. s_ready=0 during each EMIT.
- FRAME_LEN=8, HOP=4, input -3,-2,-1 with s_last on -1 -> frame [-3,-2,-1,0,0,0,0,0] with sign-correct real parts. Then FILL resumes with count 0; next input 7 is the first sample of the next frame.
- m_ready toggling pseudo-randomly (50%) during frame 1..8 -> output exactly 1..8 in order with no duplicates. m_data/m_last stable while stalled. Latency 2 edges at frame start.
- rst_n pulsed low asynchronously (between edges) after 5 samples -> all outputs 0 within the same cycle. After release, input 10..17 -> frame 10..17 only.
- CNT_W=2, FRAME_LEN=4, HOP=4, 20 samples -> frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT framing front-end
package fft_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_REFILL = 2'd2,
        ST_PAD    = 2'd3
    } fft_state_t;

    localparam int CPLX_MAX_W = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Places im above re, each w bits wide; callers truncate to 2*w.
    function automatic logic [2*CPLX_MAX_W-1:0] cplx_pack(
        input logic [CPLX_MAX_W-1:0] im_v,
        input logic [CPLX_MAX_W-1:0] re_v,
        input int unsigned           w
    );
        logic [2*CPLX_MAX_W-1:0] mask;
        mask = {(2*CPLX_MAX_W){1'b1}} >> (2*CPLX_MAX_W - w);
        return ((((2*CPLX_MAX_W)'(im_v)) & mask) << w) | (((2*CPLX_MAX_W)'(re_v)) & mask);
    endfunction

endpackage

// File: rtl/frame_sample_ram.sv
// rtl/frame_sample_ram.sv - simple dual-port sample store, registered read, no content reset
module frame_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - overlapping frame generator feeding the FFT slave port
module fft_frame_streamer
    import fft_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int CNT_W     = 16
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [2*DATA_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [CNT_W-1:0]    frame_count,
    output logic                busy
);

    localparam int AW = clog2(FRAME_LEN);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
    localparam logic [CW-1:0] HOP_CNT   = CW'(HOP);

    fft_state_t          state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       need_q, need_d, rd_left_q, rd_left_d;
    logic                flush_q, flush_d;
    logic                rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic                skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [2*DATA_W-1:0] m_data_q, m_data_d;
    logic                s_ready_q, s_ready_d, busy_q, busy_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;

    logic                ram_we, ram_re;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;
    logic                s_xfer, m_xfer, frame_done;
    logic [1:0]          occ;

    frame_sample_ram #(.DATA_W(DATA_W), .DEPTH(FRAME_LEN), .ADDR_W(AW)) u_ram (
        .clk   (sclk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        need_d      = need_q;
        rd_left_d   = rd_left_q;
        flush_d     = flush_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        fcnt_d      = fcnt_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_wdata   = s_data;
        frame_done  = 1'b0;
        s_xfer      = s_valid && s_ready_q;
        m_xfer      = m_valid_q && m_ready;
        occ         = 2'(m_valid_q) + 2'(skid_vld_q) + 2'(rd_vld_q);

        case (state_q)
            ST_FILL, ST_REFILL: begin
                if (s_xfer) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    need_d = need_q - 1'b1;
                    if (need_q == CW'(1)) begin
                        frame_done = 1'b1;
                        flush_d    = s_last;
                    end else if (s_last) begin
                        state_d = ST_PAD;
                        flush_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                ram_we    = 1'b1;
                ram_wdata = '0;
                wptr_d    = wptr_q + 1'b1;
                need_d    = need_q - 1'b1;
                if (need_q == CW'(1)) frame_done = 1'b1;
            end
            ST_EMIT: begin
                // Only issue a read if out + skid can absorb it once it lands.
                ram_re = (rd_left_q != '0) && ((occ < 2'd2) || (occ == 2'd2 && m_xfer));
                if (ram_re) begin
                    rptr_d    = rptr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                end
                if (m_xfer && m_last_q) begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (flush_q) begin
                        flush_d = 1'b0;
                        need_d  = FRAME_CNT;
                        wptr_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        need_d  = HOP_CNT;
                        state_d = ST_REFILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (frame_done) begin
            state_d   = ST_EMIT;
            rptr_d    = wptr_d;
            rd_left_d = FRAME_CNT;
        end

        rd_vld_d  = ram_re;
        rd_last_d = ram_re && (rd_left_q == CW'(1));

        // Skid holds the older word, so it drains into the output first.
        if (!m_valid_q || m_xfer) begin
            if (skid_vld_q) begin
                m_valid_d   = 1'b1;
                m_data_d    = (2*DATA_W)'(cplx_pack('0, CPLX_MAX_W'(skid_data_q), DATA_W));
                m_last_d    = skid_last_q;
                skid_vld_d  = rd_vld_q;
                skid_data_d = ram_rdata;
                skid_last_d = rd_last_q;
            end else if (rd_vld_q) begin
                m_valid_d = 1'b1;
                m_data_d  = (2*DATA_W)'(cplx_pack('0, CPLX_MAX_W'(ram_rdata), DATA_W));
                m_last_d  = rd_last_q;
            end else begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        end else if (rd_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_data_d = ram_rdata;
            skid_last_d = rd_last_q;
        end

        s_ready_d = (state_d == ST_FILL) || (state_d == ST_REFILL);
        busy_d    = !((state_d == ST_FILL) && (need_d == FRAME_CNT));
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wptr_q      <= '0;
            rptr_q      <= '0;
            need_q      <= FRAME_CNT;
            rd_left_q   <= '0;
            flush_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            need_q      <= need_d;
            rd_left_q   <= rd_left_d;
            flush_q     <= flush_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_data      = m_data_q;
    assign frame_count = fcnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb/tb_fft_frame_streamer.sv - directed self-checking bench for fft_frame_streamer
module tb_fft_frame_streamer;

    localparam int ND = 3;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data [ND];
    logic        s_valid [ND];
    logic        s_last [ND];
    logic        s_ready [ND];
    logic        m_valid [ND];
    logic        m_ready [ND];
    logic        m_last [ND];
    logic        busy [ND];
    logic [31:0] m_data [ND];
    logic [15:0] fc0, fc1;
    logic [1:0]  fc2;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int act = 0;
    int xfer_cyc = 0;
    int first_v_cyc = -1;
    int imag_bad = 0;
    int stall_bad = 0;
    int sready_bad = 0;

    logic [15:0] oq [$];
    logic        lq [$];
    logic [1:0]  fcq [$];
    logic [1:0]  prev_fc2 = 2'd0;
    logic        hold_v [ND];
    logic        hold_l [ND];
    logic        prev_mv [ND];
    logic [31:0] hold_d [ND];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    fft_frame_streamer #(.DATA_W(16), .FRAME_LEN(8), .HOP(8), .CNT_W(16)) u_h8 (
        .sclk(sclk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_last(m_last[0]), .frame_count(fc0), .busy(busy[0]));

    fft_frame_streamer #(.DATA_W(16), .FRAME_LEN(8), .HOP(4), .CNT_W(16)) u_h4 (
        .sclk(sclk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_last(m_last[1]), .frame_count(fc1), .busy(busy[1]));

    fft_frame_streamer #(.DATA_W(16), .FRAME_LEN(4), .HOP(4), .CNT_W(2)) u_c2 (
        .sclk(sclk), .rst_n(rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_last(s_last[2]),
        .s_ready(s_ready[2]), .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
        .m_last(m_last[2]), .frame_count(fc2), .busy(busy[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Outputs are observed on the falling edge, inputs change just after the rising edge.
    always @(negedge sclk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                hold_v[d]  = 1'b0;
                prev_mv[d] = 1'b0;
            end else begin
                if (m_valid[d] && m_ready[d]) begin
                    if (d == act) begin
                        oq.push_back(m_data[d][15:0]);
                        lq.push_back(m_last[d]);
                    end
                    if (m_data[d][31:16] != 16'd0) imag_bad++;
                end
                if (hold_v[d] && (!m_valid[d] || m_data[d] != hold_d[d] || m_last[d] != hold_l[d]))
                    stall_bad++;
                if (m_valid[d] && s_ready[d]) sready_bad++;
                if (d == act && m_valid[d] && !prev_mv[d] && first_v_cyc < 0) first_v_cyc = cyc;
                hold_v[d]  = m_valid[d] && !m_ready[d];
                hold_d[d]  = m_data[d];
                hold_l[d]  = m_last[d];
                prev_mv[d] = m_valid[d];
            end
        end
        if (fc2 != prev_fc2) begin
            fcq.push_back(fc2);
            prev_fc2 = fc2;
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic assert_reset(input bit chk);
        #3;
        rst_n = 1'b0;
        #1;
        if (chk) begin
            check_eq("rst_s_ready", 32'(s_ready[0]), 32'd0);
            check_eq("rst_m_valid", 32'(m_valid[0]), 32'd0);
            check_eq("rst_m_last", 32'(m_last[0]), 32'd0);
            check_eq("rst_m_data", m_data[0], 32'd0);
            check_eq("rst_busy", 32'(busy[0]), 32'd0);
            check_eq("rst_frame_count", 32'(fc0), 32'd0);
        end
    endtask

    task automatic release_reset(input bit chk);
        repeat (2) @(posedge sclk);
        #2;
        rst_n = 1'b1;
        oq.delete();
        lq.delete();
        fcq.delete();
        prev_fc2    = 2'd0;
        first_v_cyc = -1;
        imag_bad    = 0;
        stall_bad   = 0;
        sready_bad  = 0;
        tick();
        if (chk) check_eq("post_rst_s_ready", 32'(s_ready[0]), 32'd1);
    endtask

    task automatic do_reset(input bit chk);
        tick();
        assert_reset(chk);
        release_reset(chk);
    endtask

    task automatic send(input int d, input logic [15:0] v, input logic l);
        int n;
        n = 0;
        s_data[d]  = v;
        s_valid[d] = 1'b1;
        s_last[d]  = l;
        while (!s_ready[d] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("send_timeout", 32'(n), 32'd0);
        tick();
        xfer_cyc   = cyc;
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic send_range(input int d, input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send(d, 16'(v), 1'b0);
    endtask

    task automatic wait_outs(input string tag, input int n);
        int k;
        k = 0;
        while (oq.size() < n && k < 400) begin
            tick();
            k++;
        end
        repeat (12) tick();
        check_eq({tag, "_count"}, 32'(oq.size()), 32'(n));
    endtask

    task automatic check_stream(input string tag, input logic [15:0] e [$], input int fl);
        for (int i = 0; i < e.size(); i++) begin
            if (i < oq.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), 32'(oq[i]), 32'(e[i]));
                check_eq($sformatf("%s_last%0d", tag, i), 32'(lq[i]), 32'((i % fl) == fl - 1));
            end
        end
    endtask

    logic [15:0] e [$];
    logic [1:0]  fexp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        for (int d = 0; d < ND; d++) begin
            s_data[d]  = '0;
            s_valid[d] = 1'b0;
            s_last[d]  = 1'b0;
            m_ready[d] = 1'b1;
        end

        // No overlap: two back-to-back frames
        act = 0;
        do_reset(1'b1);
        send_range(0, 1, 16);
        wait_outs("a", 16);
        e = {};
        for (int v = 1; v <= 16; v++) e.push_back(16'(v));
        check_stream("a", e, 8);
        check_eq("a_frame_count", 32'(fc0), 32'd2);
        check_eq("a_imag_zero", 32'(imag_bad), 32'd0);

        // Half overlap
        act = 1;
        do_reset(1'b0);
        send_range(1, 1, 16);
        wait_outs("b", 24);
        e = {};
        for (int v = 1; v <= 8; v++) e.push_back(16'(v));
        for (int v = 5; v <= 12; v++) e.push_back(16'(v));
        for (int v = 9; v <= 16; v++) e.push_back(16'(v));
        check_stream("b", e, 8);
        check_eq("b_frame_count", 32'(fc1), 32'd3);
        check_eq("b_s_ready_in_emit", 32'(sready_bad), 32'd0);

        // Short utterance padded with zeros, then a fresh utterance
        act = 1;
        do_reset(1'b0);
        send(1, 16'hfffd, 1'b0);
        send(1, 16'hfffe, 1'b0);
        send(1, 16'hffff, 1'b1);
        wait_outs("c", 8);
        e = '{16'hfffd, 16'hfffe, 16'hffff, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        check_stream("c", e, 8);
        check_eq("c_busy_idle", 32'(busy[1]), 32'd0);
        check_eq("c_s_ready_idle", 32'(s_ready[1]), 32'd1);
        oq.delete();
        lq.delete();
        send_range(1, 7, 14);
        wait_outs("c2", 8);
        e = {};
        for (int v = 7; v <= 14; v++) e.push_back(16'(v));
        check_stream("c2", e, 8);

        // Random back-pressure on the first frame
        act = 0;
        do_reset(1'b0);
        fork
            send_range(0, 1, 8);
            begin
                int k;
                k = 0;
                while (oq.size() < 8 && k < 400) begin
                    m_ready[0] = 1'($urandom_range(0, 1));
                    tick();
                    k++;
                end
                m_ready[0] = 1'b1;
            end
        join
        wait_outs("d", 8);
        e = {};
        for (int v = 1; v <= 8; v++) e.push_back(16'(v));
        check_stream("d", e, 8);
        check_eq("d_stall_stable", 32'(stall_bad), 32'd0);
        check_eq("d_latency", 32'(first_v_cyc - xfer_cyc), 32'd2);

        // Reset while a stalled frame is being presented
        act = 0;
        do_reset(1'b0);
        m_ready[0] = 1'b0;
        send_range(0, 1, 8);
        repeat (4) tick();
        check_eq("e_stalled_valid", 32'(m_valid[0]), 32'd1);
        check_eq("e_stalled_data", m_data[0], 32'd1);
        assert_reset(1'b1);
        m_ready[0] = 1'b1;
        release_reset(1'b0);

        // Reset after a partial fill: partial frame discarded
        send_range(0, 1, 5);
        assert_reset(1'b1);
        release_reset(1'b1);
        send_range(0, 10, 17);
        wait_outs("e", 8);
        e = {};
        for (int v = 10; v <= 17; v++) e.push_back(16'(v));
        check_stream("e", e, 8);
        check_eq("e_frame_count", 32'(fc0), 32'd1);

        // s_last on the very first sample
        act = 2;
        do_reset(1'b0);
        send(2, 16'd5, 1'b1);
        wait_outs("f", 4);
        e = '{16'd5, 16'd0, 16'd0, 16'd0};
        check_stream("f", e, 4);

        // Frame counter wrap with CNT_W=2
        do_reset(1'b0);
        send_range(2, 1, 20);
        wait_outs("g", 20);
        check_eq("g_fc_changes", 32'(fcq.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < fcq.size()) check_eq($sformatf("g_fc%0d", i), 32'(fcq[i]), 32'(fexp[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks expected completion", n_chk);
        $fatal(1);
    end

endmodule
